// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor controller.
// Operands are latched on a start request and processed LSB first, one bit
// pair per clock, through a single sum/carry stage with a registered carry.
// Subtraction is a + ~b + 1: b is inverted bit by bit and the carry is
// preloaded with 1. The final sum, carry/borrow and signed overflow are
// registered on entry to DONE, where a one-cycle done pulse is raised.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
    output logic             out_ov
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    count;
    logic             op;
    logic             carry;

    logic             b_bit;
    logic             sum_bit;
    logic             c_next;
    logic [WIDTH-1:0] result_next;

    // One-bit full-adder stage fed by the current LSBs and the carry register
    always_comb begin
        b_bit       = reg_b[0] ^ op;
        sum_bit     = reg_a[0] ^ b_bit ^ carry;
        c_next      = (reg_a[0] & b_bit) | (reg_a[0] & carry) | (b_bit & carry);
        result_next = {sum_bit, result[WIDTH-1:1]};
    end

    // Controller FSM: latch operands, run WIDTH bit steps, present result.
    // On the last step the carry register still holds the carry into the MSB,
    // so the overflow is that value XOR the final carry out.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= IDLE;
            reg_a    <= '0;
            reg_b    <= '0;
            result   <= '0;
            count    <= '0;
            op       <= 1'b0;
            carry    <= 1'b0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
            out_s    <= '0;
            out_co   <= 1'b0;
            out_ov   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    out_done <= 1'b0;
                    if (in_start) begin
                        reg_a    <= in_a;
                        reg_b    <= in_b;
                        op       <= in_op;
                        carry    <= in_op;
                        count    <= '0;
                        result   <= '0;
                        out_busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        out_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    reg_a  <= reg_a >> 1;
                    reg_b  <= reg_b >> 1;
                    carry  <= c_next;
                    result <= result_next;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        out_s    <= result_next;
                        out_co   <= c_next ^ op;
                        out_ov   <= carry ^ c_next;
                        out_done <= 1'b1;
                        out_busy <= 1'b0;
                        state    <= DONE;
                    end else begin
                        out_done <= 1'b0;
                        out_busy <= 1'b1;
                    end
                end
                default: begin
                    out_done <= 1'b0;
                    out_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
